// File: rtl/decoder_pkg.sv
// Shared definitions for the K=3, rate-1/2 hard-decision Viterbi decoder.
package decoder_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  localparam int unsigned TB_DEPTH_DEF = 16;
  localparam int unsigned PM_W_DEF     = 5;
  localparam int unsigned PM_INIT_DEF  = 8;

  typedef logic [1:0]          state_t;
  typedef logic [PM_W_DEF-1:0] pm_t;

  // Hamming distance between the received pair and the pair the encoder
  // emits when bit b leaves predecessor state pred = {d1,d2}.
  function automatic logic [1:0] bmetric(input state_t pred, input logic b,
                                         input logic rx_x, input logic rx_y);
    logic [2:0] sr;
    logic       ex;
    logic       ey;
    sr = {b, pred};
    ex = ^(sr & G0);
    ey = ^(sr & G1);
    return {1'b0, ex ^ rx_x} + {1'b0, ey ^ rx_y};
  endfunction

endpackage

// File: rtl/decoder_acs.sv
// Two-candidate add-compare-select; ties keep the d2=0 predecessor (cand 0).
module decoder_acs
  import decoder_pkg::*;
#(
  parameter int unsigned PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    cand0 = pm0_i + {{(PM_W-2){1'b0}}, bm0_i};
    cand1 = pm1_i + {{(PM_W-2){1'b0}}, bm1_i};
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule

// File: rtl/decoder.sv
// Viterbi decoder top: four ACS units, metric normalisation, register-exchange
// survivors and best-state output selection.
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned TB_DEPTH = TB_DEPTH_DEF,
  parameter int unsigned PM_W     = PM_W_DEF,
  parameter int unsigned PM_INIT  = PM_INIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in_x,
  input  logic in_y,
  output logic out,
  output logic flag
);

  localparam int unsigned CNT_W = $clog2(TB_DEPTH);

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [PM_W-1:0]     acs_pm [4];
  logic [PM_W-1:0]     min_pm;
  logic [TB_DEPTH-1:0] hist_q [4];
  logic [TB_DEPTH-1:0] hist_d [4];
  logic [3:0]          dec;
  state_t              min_idx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                flag_q, flag_d;

  // New state {b,d1} is reached from {d1,0} (cand 0) or {d1,1} (cand 1).
  for (genvar g = 0; g < 4; g++) begin : g_state
    localparam state_t NS = state_t'(g);
    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = bmetric(P0, NS[1], in_x, in_y);
    assign bm1 = bmetric(P1, NS[1], in_x, in_y);

    decoder_acs #(.PM_W(PM_W)) u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (acs_pm[g]),
      .dec_o (dec[g])
    );

    assign hist_d[g] = {(dec[g] ? hist_q[P1][TB_DEPTH-2:0]
                                : hist_q[P0][TB_DEPTH-2:0]), NS[1]};
  end

  always_comb begin
    min_pm  = acs_pm[0];
    min_idx = '0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm  = acs_pm[i];
        min_idx = state_t'(i);
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      pm_d[i] = acs_pm[i] - min_pm;
    end
    out_d  = hist_d[min_idx][TB_DEPTH-1];
    flag_d = (cnt_q == CNT_W'(TB_DEPTH-1));
    cnt_d  = cnt_q;
    if (!flag_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pm_q[0] <= '0;
      for (int unsigned i = 1; i < 4; i++) begin
        pm_q[i] <= PM_W'(PM_INIT);
      end
      for (int unsigned i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      cnt_q  <= '0;
      out_q  <= 1'b0;
      flag_q <= 1'b0;
    end else if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        hist_q[i] <= hist_d[i];
      end
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      flag_q <= flag_d;
    end else begin
      flag_q <= 1'b0;
    end
  end

  assign out  = out_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_decoder.sv
// Directed, table-driven bench for the Viterbi decoder.
module tb_decoder;

  logic clk = 1'b0;
  logic reset, en, in_x, in_y;
  logic out, flag;

  int unsigned checks = 0;
  int unsigned errors = 0;

  decoder dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .in_x  (in_x),
    .in_y  (in_y),
    .out   (out),
    .flag  (flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic x;
    logic y;
    logic exp_flag;
    logic exp_out;
  } vec_t;

  vec_t       tbl [24];
  logic [23:0] known_bits;
  logic [63:0] pbits, px, py;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic x, input logic y);
    @(negedge clk);
    en   = e;
    in_x = x;
    in_y = y;
    @(posedge clk);
    #1;
  endtask

  // Reset is held for one edge with en=1 to show it overrides en.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    in_x  = 1'b1;
    in_y  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
  endtask

  task automatic run_table(input string tag, input logic flip);
    for (int i = 0; i < 24; i++) begin
      logic yy;
      yy = tbl[i].y ^ (flip && (i == 1));
      step(1'b1, tbl[i].x, yy);
      check({tag, "_flag"}, {7'd0, flag}, {7'd0, tbl[i].exp_flag});
      if (tbl[i].exp_flag) check({tag, "_out"}, {7'd0, out}, {7'd0, tbl[i].exp_out});
    end
  endtask

  initial begin
    logic d1, d2, b;
    reset = 1'b0;
    en    = 1'b0;
    in_x  = 1'b0;
    in_y  = 1'b0;

    // Known stream 1,0,1,1 then zeros. Pairs 0..5 are 11,10,00,01 followed by
    // 01,11 (the encoder flushing d1/d2), then 00 for the remaining zeros.
    known_bits = 24'b0000_0000_0000_0000_0000_1101;  // bit k at index k
    for (int i = 0; i < 24; i++) begin
      tbl[i].x        = 1'b0;
      tbl[i].y        = 1'b0;
      tbl[i].exp_flag = (i >= 15);
      tbl[i].exp_out  = (i >= 15) ? known_bits[i-15] : 1'b0;
    end
    tbl[0].x = 1'b1; tbl[0].y = 1'b1;
    tbl[1].x = 1'b1; tbl[1].y = 1'b0;
    tbl[2].x = 1'b0; tbl[2].y = 1'b0;
    tbl[3].x = 1'b0; tbl[3].y = 1'b1;
    tbl[4].x = 1'b0; tbl[4].y = 1'b1;
    tbl[5].x = 1'b1; tbl[5].y = 1'b1;

    // Periodic pattern: seven 0s then a 1, encoded from state 0.
    d1 = 1'b0;
    d2 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      b        = ((k % 8) == 7);
      pbits[k] = b;
      px[k]    = b ^ d1 ^ d2;
      py[k]    = b ^ d2;
      d2       = d1;
      d1       = b;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {7'd0, out}, 8'd0);
    check("reset_flag", {7'd0, flag}, 8'd0);
    reset = 1'b1;

    // Tie case: pair 01 from reset. States 0 and 2 reach 1, states 1 and 3
    // reach 8+0; subtracting the minimum 1 leaves {0,7,0,7}.
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    check("tie_flag", {7'd0, flag}, 8'd0);
    check("tie_out", {7'd0, out}, 8'd0);
    check("tie_pm0", {3'd0, dut.pm_q[0]}, 8'd0);
    check("tie_pm1", {3'd0, dut.pm_q[1]}, 8'd7);
    check("tie_pm2", {3'd0, dut.pm_q[2]}, 8'd0);
    check("tie_pm3", {3'd0, dut.pm_q[3]}, 8'd7);

    // All-zero stream
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check("zero_flag", {7'd0, flag}, {7'd0, (k >= 15)});
      if (k >= 15) check("zero_out", {7'd0, out}, 8'd0);
      check("zero_pm0", {3'd0, dut.pm_q[0]}, 8'd0);
    end

    // Known sequence, then the same with one channel error on pair 1
    do_reset();
    run_table("known", 1'b0);
    do_reset();
    run_table("err1", 1'b1);

    // Periodic stream with en toggling; idle cycles carry garbage pairs
    do_reset();
    for (int k = 0; k < 64; k++) begin
      step(1'b1, px[k], py[k]);
      check("per_flag", {7'd0, flag}, {7'd0, (k >= 15)});
      if (k >= 15) check("per_out", {7'd0, out}, {7'd0, pbits[k-15]});
      step(1'b0, ~px[k], ~py[k]);
      check("per_idle_flag", {7'd0, flag}, 8'd0);
      if (k >= 15) check("per_hold_out", {7'd0, out}, {7'd0, pbits[k-15]});
    end

    // Reset mid-stream after 10 symbols, then a fresh known stream
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    do_reset();
    check("mid_reset_out", {7'd0, out}, 8'd0);
    check("mid_reset_flag", {7'd0, flag}, 8'd0);
    run_table("restart", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
